// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state encoding and default timeout shared by the frequency meter.
package freq_meter_pkg;
    localparam logic [0:0] WAIT_FIRST = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;
    localparam int TIMEOUT_DEFAULT = 50_000_000;
endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: 2-FF synchronizer with history flop, flags rising edges of an async input.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise
);
    logic [1:0] meta;
    logic hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            hist <= 1'b0;
        end else begin
            meta <= {meta[0], din};
            hist <= meta[1];
        end
    end
    assign sync = meta[1];
    assign rise = meta[1] & ~hist;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of sig_in in clki cycles, flags stale input.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CW = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clki,
    input  logic          rst_n,
    input  logic          sig_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          valid,
    output logic          stale
);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE = CW'(1);
    logic [0:0] state;
    logic [CW-1:0] cnt, hcnt;
    logic sync, rise;
    sync_edge u_sync (
        .clk  (clki),
        .rst_n(rst_n),
        .din  (sig_in),
        .sync (sync),
        .rise (rise)
    );
    // An edge on the timeout cycle takes priority over declaring the input stale.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_FIRST;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stale     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == WAIT_FIRST) begin
                if (rise) begin
                    state <= MEASURE;
                    cnt   <= ONE;
                    hcnt  <= ONE;
                end
            end else if (rise) begin
                period    <= cnt;
                high_time <= hcnt;
                valid     <= 1'b1;
                stale     <= 1'b0;
                cnt       <= ONE;
                hcnt      <= ONE;
            end else if (cnt == LIMIT) begin
                state     <= WAIT_FIRST;
                stale     <= 1'b1;
                period    <= '0;
                high_time <= '0;
                cnt       <= '0;
                hcnt      <= '0;
            end else begin
                cnt  <= cnt + ONE;
                hcnt <= hcnt + CW'(sync);
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random and directed waveforms checked cycle by cycle against a timestamp model.
module tb_freq_meter;
    localparam int TIMEOUT = 1000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig_in = 1'b0;
    logic [31:0] period, high_time;
    logic valid, stale;
    int checks = 0;
    int errors = 0;

    freq_meter #(.CW(32), .TIMEOUT(TIMEOUT)) dut (
        .clki     (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference: edges are timestamps in the synchronized stream (input delayed by two samples);
    // a measurement is the gap between consecutive edges, stale when the gap reaches TIMEOUT.
    bit q[$];
    bit s2, s2prev, armed, m_valid, m_stale;
    int t, last, hc, m_per, m_ht;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q = '{1'b0, 1'b0};
            s2prev = 0; armed = 0; t = 0; last = 0; hc = 0;
            m_valid = 0; m_per = 0; m_ht = 0; m_stale = 0;
        end else begin
            t++;
            s2 = q.pop_front();
            q.push_back(sig_in);
            m_valid = 0;
            if (s2 && !s2prev) begin
                if (armed) begin
                    m_valid = 1; m_per = t - last; m_ht = hc; m_stale = 0;
                end
                armed = 1; last = t; hc = 0;
            end else if (armed && t - last == TIMEOUT) begin
                armed = 0; m_stale = 1; m_per = 0; m_ht = 0;
            end
            if (s2) hc++;
            s2prev = s2;
        end
    end

    always @(negedge clk) begin
        check("valid", valid, m_valid);
        check("period", period, m_per);
        check("high_time", high_time, m_ht);
        check("stale", stale, m_stale);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Glitches are narrower than the clock-low phase so they never straddle a sampling edge.
    task automatic wave(input int per, input int hi, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            cycles(hi);
            sig_in = 1'b0;
            for (int j = 0; j < per - hi; j++) begin
                @(negedge clk);
                if (glitch && j % 7 == 3) begin
                    #1 sig_in = 1'b1;
                    #2 sig_in = 1'b0;
                end
            end
        end
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        #1;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_stale", stale, 0);
        cycles(2);
        wave(100, 50, 5, 0);
        wave(100, 30, 5, 0);
        wave(100, 50, 2, 0);
        cycles(1200);
        wave(100, 50, 3, 0);
        wave(1000, 500, 3, 0);
        wave(1001, 10, 2, 0);
        wave(100, 50, 3, 0);
        sig_in = 1'b1;
        cycles(20);
        #2 rst_n = 1'b0;
        #1;
        check("async_period", period, 0);
        check("async_high", high_time, 0);
        check("async_valid", valid, 0);
        check("async_stale", stale, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(30);
        sig_in = 1'b0;
        cycles(50);
        wave(100, 40, 3, 0);
        wave(200, 90, 4, 1);
        for (int k = 0; k < 30; k++) begin
            int per, hi;
            per = int'($urandom_range(4, 400));
            hi = int'($urandom_range(1, per - 1));
            wave(per, hi, int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) cycles(int'($urandom_range(900, 1100)));
        end
        cycles(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
